// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: D = A - B, one bit per clock, LSB first.
// start/busy/done handshake; D, Bout and V hold until the next operation completes.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             V
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-1:0] work_reg;
    logic [CW-1:0]    cnt_reg;
    logic             borrow_reg;
    logic             a_msb_reg;
    logic             b_msb_reg;
    logic             busy_reg;
    logic             done_reg;
    logic [WIDTH-1:0] d_reg;
    logic             bout_reg;
    logic             v_reg;

    logic             a_bit;
    logic             b_bit;
    logic             diff_bit;
    logic             borrow_next;
    logic [WIDTH-1:0] work_next;

    // One full-subtractor cell; the difference bit enters the working register at the MSB.
    always_comb begin
        a_bit       = a_sh_reg[0];
        b_bit       = b_sh_reg[0];
        diff_bit    = a_bit ^ b_bit ^ borrow_reg;
        borrow_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & borrow_reg);
        work_next   = {diff_bit, work_reg[WIDTH-1:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            work_reg   <= '0;
            cnt_reg    <= '0;
            borrow_reg <= 1'b0;
            a_msb_reg  <= 1'b0;
            b_msb_reg  <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            d_reg      <= '0;
            bout_reg   <= 1'b0;
            v_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        a_sh_reg   <= A;
                        b_sh_reg   <= B;
                        a_msb_reg  <= A[WIDTH-1];
                        b_msb_reg  <= B[WIDTH-1];
                        work_reg   <= '0;
                        borrow_reg <= 1'b0;
                        cnt_reg    <= '0;
                        busy_reg   <= 1'b1;
                        state_reg  <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sh_reg   <= a_sh_reg >> 1;
                    b_sh_reg   <= b_sh_reg >> 1;
                    work_reg   <= work_next;
                    borrow_reg <= borrow_next;
                    if (cnt_reg == LAST_BIT) begin
                        // Results are published only here, so an aborted run never touches them.
                        d_reg     <= work_next;
                        bout_reg  <= borrow_next;
                        v_reg     <= (a_msb_reg ^ b_msb_reg) & (work_next[WIDTH-1] ^ a_msb_reg);
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign D    = d_reg;
    assign Bout = bout_reg;
    assign V    = v_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8 and WIDTH=2 instances) against
// an arithmetic reference model of A - B.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       busy8, done8, bout8, v8;
    logic [7:0] d8;
    logic       start2 = 1'b0;
    logic [1:0] a2 = '0;
    logic [1:0] b2 = '0;
    logic       busy2, done2, bout2, v2;
    logic [1:0] d2;

    int checks = 0;
    int failures = 0;

    // Currently held (expected) results of the 8-bit instance
    int exp_d8 = 0;
    bit exp_bo8 = 1'b0;
    bit exp_v8 = 1'b0;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8),
        .busy(busy8), .done(done8), .D(d8), .Bout(bout8), .V(v8)
    );

    serial_subtractor #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .A(a2), .B(b2),
        .busy(busy2), .done(done2), .D(d2), .Bout(bout2), .V(v2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: plain modular and signed arithmetic on the operand values
    task automatic ref_sub(input int a, input int b, input int w,
                           output int d, output bit bo, output bit v);
        int sa, sb, diff;
        d  = (a - b) & ((1 << w) - 1);
        bo = (a < b);
        sa = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
        sb = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
        diff = sa - sb;
        v  = (diff > (1 << (w - 1)) - 1) || (diff < -(1 << (w - 1)));
    endtask

    // One 8-bit operation; optionally scramble A/B during SHIFT and pulse start in cycle 4
    task automatic do_op8(input logic [7:0] a, input logic [7:0] b,
                          input bit scramble, input bit pulse_c4);
        int  d;
        bit  bo, v;
        ref_sub(int'(a), int'(b), 8, d, bo, v);
        @(negedge clk);
        a8 = a; b8 = b; start8 = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            start8 = (pulse_c4 && c == 4);
            check("busy8_shift", 32'(busy8), 32'd1);
            check("done8_shift", 32'(done8), 32'd0);
            check("d8_held", 32'(d8), 32'(exp_d8));
            if (scramble || c == 4) begin
                a8 = 8'($urandom);
                b8 = 8'($urandom);
            end
        end
        @(negedge clk);
        start8 = 1'b0;
        check("done8_pulse", 32'(done8), 32'd1);
        check("busy8_done", 32'(busy8), 32'd0);
        check("d8", 32'(d8), 32'(d));
        check("bout8", 32'(bout8), 32'(bo));
        check("v8", 32'(v8), 32'(v));
        exp_d8 = d; exp_bo8 = bo; exp_v8 = v;
        @(negedge clk);
        check("done8_clear", 32'(done8), 32'd0);
        check("busy8_idle", 32'(busy8), 32'd0);
        $display("op8 A=%02h B=%02h -> D=%02h Bout=%0d V=%0d (exp %02h %0d %0d)",
                 a, b, d8, bout8, v8, d, bo, v);
    endtask

    task automatic do_op2(input logic [1:0] a, input logic [1:0] b);
        int d;
        bit bo, v;
        ref_sub(int'(a), int'(b), 2, d, bo, v);
        @(negedge clk);
        a2 = a; b2 = b; start2 = 1'b1;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            start2 = 1'b0;
            check("busy2_shift", 32'(busy2), 32'd1);
            check("done2_shift", 32'(done2), 32'd0);
        end
        @(negedge clk);
        check("done2_pulse", 32'(done2), 32'd1);
        check("busy2_done", 32'(busy2), 32'd0);
        check("d2", 32'(d2), 32'(d));
        check("bout2", 32'(bout2), 32'(bo));
        check("v2", 32'(v2), 32'(v));
        @(negedge clk);
        check("done2_clear", 32'(done2), 32'd0);
        $display("op2 A=%0b B=%0b -> D=%0b Bout=%0d V=%0d (exp %0d %0d %0d)",
                 a, b, d2, bout2, v2, d, bo, v);
    endtask

    initial begin
        int done_seen;
        repeat (3) @(negedge clk);
        check("rst_busy8", 32'(busy8), 32'd0);
        check("rst_done8", 32'(done8), 32'd0);
        check("rst_d8", 32'(d8), 32'd0);
        check("rst_bout8", 32'(bout8), 32'd0);
        check("rst_v8", 32'(v8), 32'd0);
        rst = 1'b0;

        // Directed cases, with held-result / ignored-start test after the first
        do_op8(8'h05, 8'h03, 1'b0, 1'b0);
        do_op8(8'h40, 8'h10, 1'b0, 1'b1);
        repeat (2) begin
            @(negedge clk);
            check("start_not_queued", 32'(busy8), 32'd0);
        end
        do_op8(8'h03, 8'h05, 1'b0, 1'b0);
        do_op8(8'h80, 8'h01, 1'b0, 1'b0);
        do_op8(8'h7F, 8'hFF, 1'b0, 1'b0);

        // Asynchronous reset mid-operation (cycle 5)
        @(negedge clk);
        a8 = 8'h55; b8 = 8'h22; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy8", 32'(busy8), 32'd0);
        check("arst_done8", 32'(done8), 32'd0);
        check("arst_d8", 32'(d8), 32'd0);
        check("arst_bout8", 32'(bout8), 32'd0);
        check("arst_v8", 32'(v8), 32'd0);
        exp_d8 = 0; exp_bo8 = 1'b0; exp_v8 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done8 || busy8) done_seen++;
        end
        check("no_done_after_abort", 32'(done_seen), 32'd0);
        // Start in the very first cycle after release
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        do_op8(8'hFF, 8'hFF, 1'b0, 1'b0);

        // start held high for 30 cycles: done in cycles 9, 19, 29
        @(negedge clk);
        a8 = 8'h10; b8 = 8'h01; start8 = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (c == 30) start8 = 1'b0;
            check("held_start_done", 32'(done8), 32'(c == 9 || c == 19 || c == 29));
            if (c == 9 || c == 19 || c == 29) begin
                check("held_start_d", 32'(d8), 32'h0F);
                $display("held-start done at cycle %0d D=%02h", c, d8);
            end
        end
        exp_d8 = 32'h0F; exp_bo8 = 1'b0; exp_v8 = 1'b0;
        repeat (12) @(negedge clk);
        check("held_start_stopped", 32'(busy8), 32'd0);

        // Randomized operations with operand scrambling during SHIFT
        for (int i = 0; i < 40; i++) begin
            do_op8(8'($urandom), 8'($urandom), 1'b1, 1'b0);
        end

        // WIDTH=2: directed then exhaustive
        do_op2(2'b00, 2'b01);
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                do_op2(2'(a), 2'(b));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global bound so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got %0d checks", checks);
        $fatal(1, "timeout");
    end

endmodule
